// File: rtl/dht11_sensor_emu.sv
// dht11_sensor_emu: emulates a DHT11 sensor on an open-drain single-wire bus.
// Waits for a host start pulse, then autonomously sends the response
// preamble and a 40-bit frame {rh, 0, t, 0, checksum}, MSB first.
module dht11_sensor_emu #(
  parameter int CLK_PER_US   = 100,
  parameter int START_MIN_US = 18000,
  parameter int RESP_DLY_US  = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rh_data,
  input  logic [7:0] t_data,
  input  logic       corrupt_chk,
  inout  wire        dht11_io,
  output logic       busy,
  output logic       done,
  output logic [3:0] state
);

  localparam int PW    = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int TMAX0 = (START_MIN_US > RESP_DLY_US) ? START_MIN_US : RESP_DLY_US;
  localparam int TMAX  = (TMAX0 > 80) ? TMAX0 : 80;
  localparam int TW    = $clog2(TMAX + 1);

  localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_PER_US - 1);
  localparam logic [TW-1:0] T_START    = TW'(START_MIN_US);
  localparam logic [TW-1:0] T_DLY_LAST = TW'(RESP_DLY_US - 1);
  localparam logic [TW-1:0] T_80_LAST  = TW'(79);
  localparam logic [TW-1:0] T_50_LAST  = TW'(49);
  localparam logic [TW-1:0] T_70_LAST  = TW'(69);
  localparam logic [TW-1:0] T_26_LAST  = TW'(25);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_HOST_LOW  = 4'd1,
    S_WAIT_REL  = 4'd2,
    S_RESP_DLY  = 4'd3,
    S_RESP_LOW  = 4'd4,
    S_RESP_HIGH = 4'd5,
    S_BIT_LOW   = 4'd6,
    S_BIT_HIGH  = 4'd7,
    S_END_LOW   = 4'd8
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [TW-1:0]   phase_last;
  logic [5:0]      bit_q, bit_d;
  logic [39:0]     frame_q, frame_d;
  logic            drive_low_q, drive_low_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            sync1_q, sync2_q, prev_q;
  logic            tick, fall, bus_hi, phase_end, cur_bit;
  logic [7:0]      chk;

  assign bus_hi  = sync2_q;
  assign fall    = prev_q & ~sync2_q;
  assign tick    = (pre_q == PRE_LAST);
  assign cur_bit = frame_q[6'd39 - bit_q];
  assign chk     = (rh_data + t_data) ^ {8{corrupt_chk}};

  // Next-state, phase timing and frame latch for the whole emulator.
  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    bit_d       = bit_q;
    drive_low_d = drive_low_q;
    done_d      = 1'b0;
    phase_last  = '0;

    unique case (state_q)
      S_RESP_DLY:  phase_last = T_DLY_LAST;
      S_RESP_LOW,
      S_RESP_HIGH: phase_last = T_80_LAST;
      S_BIT_LOW,
      S_END_LOW:   phase_last = T_50_LAST;
      S_BIT_HIGH:  phase_last = cur_bit ? T_70_LAST : T_26_LAST;
      default:     phase_last = '0;
    endcase
    phase_end = tick && (timer_q == phase_last);

    unique case (state_q)
      S_IDLE: begin
        if (fall) state_d = S_HOST_LOW;
      end
      S_HOST_LOW: begin
        // Short pulses are treated as glitches and dropped silently.
        if (bus_hi) state_d = (timer_q >= T_START) ? S_RESP_DLY : S_IDLE;
        else if (timer_q >= T_START) state_d = S_WAIT_REL;
      end
      S_WAIT_REL: begin
        if (bus_hi) state_d = S_RESP_DLY;
      end
      S_RESP_DLY: begin
        if (phase_end) begin
          state_d     = S_RESP_LOW;
          drive_low_d = 1'b1;
        end
      end
      S_RESP_LOW: begin
        if (phase_end) begin
          state_d     = S_RESP_HIGH;
          drive_low_d = 1'b0;
        end
      end
      S_RESP_HIGH: begin
        if (phase_end) begin
          state_d     = S_BIT_LOW;
          drive_low_d = 1'b1;
        end
      end
      S_BIT_LOW: begin
        if (phase_end) begin
          state_d     = S_BIT_HIGH;
          drive_low_d = 1'b0;
        end
      end
      S_BIT_HIGH: begin
        if (phase_end) begin
          drive_low_d = 1'b1;
          if (bit_q == 6'd39) begin
            state_d = S_END_LOW;
          end else begin
            state_d = S_BIT_LOW;
            bit_d   = bit_q + 6'd1;
          end
        end
      end
      S_END_LOW: begin
        if (phase_end) begin
          state_d     = S_IDLE;
          drive_low_d = 1'b0;
          done_d      = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        drive_low_d = 1'b0;
      end
    endcase

    // Snapshot the payload once so later input changes cannot leak in.
    if (state_d == S_RESP_DLY && state_q != S_RESP_DLY) begin
      frame_d = {rh_data, 8'h00, t_data, 8'h00, chk};
      bit_d   = 6'd0;
    end

    // Every phase starts on a clean microsecond boundary.
    if (state_d != state_q) begin
      pre_d   = '0;
      timer_d = '0;
    end else begin
      pre_d   = tick ? '0 : pre_q + PW'(1);
      timer_d = tick ? timer_q + TW'(1) : timer_q;
    end

    busy_d = (state_d >= S_RESP_DLY) && (state_d <= S_END_LOW);
  end

  // All state, synchronizer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pre_q       <= '0;
      timer_q     <= '0;
      bit_q       <= '0;
      frame_q     <= '0;
      drive_low_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      timer_q     <= timer_d;
      bit_q       <= bit_d;
      frame_q     <= frame_d;
      drive_low_q <= drive_low_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sync1_q     <= dht11_io;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
    end
  end

  assign dht11_io = drive_low_q ? 1'b0 : 1'bz;
  assign busy     = busy_q;
  assign done     = done_q;
  assign state    = state_q;

endmodule

// File: tb/tb_dht11_sensor_emu.sv
// tb_dht11_sensor_emu: host-side stimulus plus a bus-decoding scoreboard monitor.
module tb_dht11_sensor_emu;

  localparam int CPU   = 2;
  localparam int START = 200;
  localparam int DLY   = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rh_data = 8'h00;
  logic [7:0] t_data = 8'h00;
  logic       corrupt_chk = 1'b0;
  logic       host_low = 1'b0;
  logic       busy, done;
  logic [3:0] state;
  wire        dht_bus;

  pullup (dht_bus);
  assign dht_bus = host_low ? 1'b0 : 1'bz;

  dht11_sensor_emu #(.CLK_PER_US(CPU), .START_MIN_US(START), .RESP_DLY_US(DLY)) dut (
    .clk(clk), .rst(rst), .rh_data(rh_data), .t_data(t_data),
    .corrupt_chk(corrupt_chk), .dht11_io(dht_bus), .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct { logic [39:0] frame; bit abort; } exp_t;
  exp_t q[$];
  int n_checks = 0;
  int n_pass = 0;
  int frame_starts = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Count consecutive negedge samples at level lvl; abort if busy drops or stuck.
  task automatic measure(input logic lvl, output int n, output bit ab);
    n = 0;
    ab = 0;
    while (dht_bus === lvl) begin
      if (busy !== 1'b1 || n > 400) begin
        ab = 1;
        break;
      end
      n++;
      @(negedge clk);
    end
  endtask

  // Monitor: decode every frame the DUT puts on the bus and score it.
  initial begin : monitor
    exp_t e;
    int n, lw, hw, dly, rl, rhh, el, lw_err, hw_err;
    bit ab;
    logic [39:0] got;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        frame_starts++;
        ab = 0; got = '0; lw_err = 0; hw_err = 0; dly = 0; rl = 0; rhh = 0; el = 0;
        measure(1'b1, dly, ab);
        if (!ab) measure(1'b0, rl, ab);
        if (!ab) measure(1'b1, rhh, ab);
        for (int i = 0; i < 40 && !ab; i++) begin
          measure(1'b0, lw, ab);
          if (!ab) measure(1'b1, hw, ab);
          if (!ab) begin
            if (lw != 50 * CPU) lw_err++;
            got = {got[38:0], (hw > 48 * CPU)};
            if (!((hw >= 26 * CPU - CPU && hw <= 26 * CPU + CPU) ||
                  (hw >= 70 * CPU - CPU && hw <= 70 * CPU + CPU))) hw_err++;
          end
        end
        if (!ab) measure(1'b0, el, ab);
        if (q.size() == 0) begin
          check("sb_unexpected_frame", 1'b1, 1'b0 & ab);
        end else begin
          e = q.pop_front();
          check("abort", ab, e.abort);
          if (!e.abort && !ab) begin
            check("resp_dly", dly, DLY * CPU);
            check("resp_low", rl, 80 * CPU);
            check("resp_high", rhh, 80 * CPU);
            check("bit_low_errs", lw_err, 0);
            check("bit_high_errs", hw_err, 0);
            check("byte_rh", got[39:32], e.frame[39:32]);
            check("byte_rh_dec", got[31:24], e.frame[31:24]);
            check("byte_t", got[23:16], e.frame[23:16]);
            check("byte_t_dec", got[15:8], e.frame[15:8]);
            check("byte_chk", got[7:0], e.frame[7:0]);
            check("end_low", el, 50 * CPU);
            check("done_pulse", done, 1'b1);
            @(negedge clk);
            check("done_width", done, 1'b0);
          end
        end
      end
    end
  end

  task automatic host_start(input int us);
    @(negedge clk);
    host_low = 1'b1;
    repeat (us * CPU) @(negedge clk);
    host_low = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 15000) begin
      @(negedge clk);
      n++;
    end
    check(name, done, 1'b1);
    repeat (20) @(negedge clk);
  endtask

  // Wait for the cnt-th entry into state st, bounded.
  task automatic wait_entries(input logic [3:0] st, input int cnt, input string name);
    int seen = 0;
    int n = 0;
    logic [3:0] prev = state;
    while (seen < cnt && n < 15000) begin
      @(negedge clk);
      n++;
      if (state == st && prev != st) seen++;
      prev = state;
    end
    check(name, seen, cnt);
  endtask

  task automatic push(input logic [39:0] f, input bit ab);
    exp_t e;
    e.frame = f;
    e.abort = ab;
    q.push_back(e);
  endtask

  initial begin : stim
    int starts0;
    repeat (4) @(negedge clk);
    check("rst_state", state, 4'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_bus", dht_bus, 1'b1);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Nominal frame: 55 / 24 -> checksum 4F.
    rh_data = 8'd55; t_data = 8'd24; corrupt_chk = 1'b0;
    push(40'h37_00_18_00_4F, 0);
    host_start(250);
    wait_done("frame_a_done");

    // Too-short start pulse: ignored entirely.
    starts0 = frame_starts;
    host_start(100);
    repeat (200) @(negedge clk);
    check("short_state", state, 4'd0);
    check("short_busy", busy, 1'b0);
    check("short_bus", dht_bus, 1'b1);
    check("short_no_frame", frame_starts, starts0);

    // Corrupted checksum: 4F inverted -> B0.
    corrupt_chk = 1'b1;
    push(40'h37_00_18_00_B0, 0);
    host_start(250);
    wait_done("frame_c_done");
    corrupt_chk = 1'b0;

    // Checksum wraparound: FF + 02 -> 01.
    rh_data = 8'hFF; t_data = 8'h02;
    push(40'hFF_00_02_00_01, 0);
    host_start(250);
    wait_done("frame_d_done");

    // Inputs change during bit 5; frame must keep latched values.
    rh_data = 8'd55; t_data = 8'd24;
    push(40'h37_00_18_00_4F, 0);
    host_start(250);
    wait_entries(4'd6, 6, "reach_bit5");
    rh_data = 8'hC8; t_data = 8'h99; corrupt_chk = 1'b1;
    wait_done("frame_e_done");
    corrupt_chk = 1'b0;

    // Reset during bit 20 abandons the frame.
    rh_data = 8'd55; t_data = 8'd24;
    push(40'h0, 1);
    host_start(250);
    wait_entries(4'd6, 21, "reach_bit20");
    rst = 1'b1;
    @(negedge clk);
    check("abort_bus", dht_bus, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_state", state, 4'd0);
    check("abort_done", done, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_done", done, 1'b0);

    // Fresh start after reset: 5A + 21 -> 7B.
    rh_data = 8'h5A; t_data = 8'h21;
    push(40'h5A_00_21_00_7B, 0);
    host_start(250);
    wait_done("frame_g_done");

    check("frame_count", frame_starts, 6);
    check("sb_drain", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
